// File: rtl/fetch_unit_pkg.sv
// Shared constants for the instruction-fetch stage: instruction word layout and FSM encodings.
package fetch_unit_pkg;
  localparam int INSTR_WORD_SIZE = 16;
  localparam int OPCODE_HI       = 15;
  localparam int OPCODE_LO       = 11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_DONE = 2'd2
  } fetch_state_t;
endpackage

// File: rtl/fetch_unit_ret_stack.sv
// Return-address LIFO: push writes at sp and increments, pop decrements; dout is the top entry.
// Push when full and pop when empty are dropped here; the caller raises the error flags.
module ret_stack #(
  parameter int DEPTH  = 8,
  parameter int DATA_W = 10,
  parameter int IDX_W  = $clog2(DEPTH),
  parameter int SP_W   = $clog2(DEPTH) + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [DATA_W-1:0] din,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic [SP_W-1:0]   sp
);
  logic [DATA_W-1:0] r_mem [DEPTH];
  logic [SP_W-1:0]   r_sp;
  logic [IDX_W-1:0]  w_top_idx;

  assign w_top_idx = IDX_W'(r_sp - SP_W'(1));
  assign dout      = r_mem[w_top_idx];
  assign full      = (r_sp == SP_W'(DEPTH));
  assign empty     = (r_sp == '0);
  assign sp        = r_sp;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_sp <= '0;
    end else if (push && !full) begin
      r_mem[r_sp[IDX_W-1:0]] <= din;
      r_sp                   <= r_sp + SP_W'(1);
    end else if (pop && !empty) begin
      r_sp <= r_sp - SP_W'(1);
    end
  end
endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: owns PC, IR and the return stack; one fetch per fetch_start, done pulses 2+wait edges later.
// Memory wait states stall in BUSY with address held; PC commands are honoured only in IDLE.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter int ADDR_W      = 10,
  parameter int RESET_PC    = 0,
  parameter int STACK_DEPTH = 8
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       fetch_start,
  input  logic                       jump_en,
  input  logic                       call_en,
  input  logic                       ret_en,
  input  logic [ADDR_W-1:0]          jump_target,
  output logic [ADDR_W-1:0]          mem_addr,
  output logic                       mem_req,
  input  logic [INSTR_WORD_SIZE-1:0] mem_rdata,
  input  logic                       mem_ack,
  output logic [INSTR_WORD_SIZE-1:0] ir,
  output logic [4:0]                 opcode,
  output logic [ADDR_W-1:0]          pc,
  output logic                       busy,
  output logic                       fetch_done,
  output logic                       err_overflow,
  output logic                       err_underflow
);
  localparam int SP_W = $clog2(STACK_DEPTH) + 1;

  fetch_state_t               r_state, w_state_nxt;
  logic [ADDR_W-1:0]          r_pc, w_pc_nxt;
  logic [INSTR_WORD_SIZE-1:0] r_ir;
  logic                       r_err_ovf, r_err_unf;
  logic                       w_push, w_pop, w_ir_load, w_ovf_set, w_unf_set;
  logic                       w_full, w_empty;
  logic [ADDR_W-1:0]          w_stack_top;
  logic [SP_W-1:0]            w_sp;

  ret_stack #(
    .DEPTH  (STACK_DEPTH),
    .DATA_W (ADDR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (w_push),
    .pop   (w_pop),
    .din   (r_pc),
    .dout  (w_stack_top),
    .full  (w_full),
    .empty (w_empty),
    .sp    (w_sp)
  );

  // Priority in IDLE: ret > call > jump > fetch_start; one action per cycle.
  always_comb begin
    w_state_nxt = r_state;
    w_pc_nxt    = r_pc;
    w_push      = 1'b0;
    w_pop       = 1'b0;
    w_ir_load   = 1'b0;
    w_ovf_set   = 1'b0;
    w_unf_set   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (ret_en) begin
          if (!w_empty) begin
            w_pop    = 1'b1;
            w_pc_nxt = w_stack_top;
          end else begin
            w_unf_set = 1'b1;
          end
        end else if (call_en) begin
          w_push    = !w_full;
          w_ovf_set = w_full;
          w_pc_nxt  = jump_target;
        end else if (jump_en) begin
          w_pc_nxt = jump_target;
        end else if (fetch_start) begin
          w_state_nxt = ST_BUSY;
        end
      end
      ST_BUSY: begin
        if (mem_ack) begin
          w_ir_load   = 1'b1;
          w_pc_nxt    = r_pc + ADDR_W'(1);
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE: w_state_nxt = ST_IDLE;
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_pc      <= ADDR_W'(RESET_PC);
      r_ir      <= '0;
      r_err_ovf <= 1'b0;
      r_err_unf <= 1'b0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_err_ovf <= r_err_ovf | w_ovf_set;
      r_err_unf <= r_err_unf | w_unf_set;
      if (w_ir_load) r_ir <= mem_rdata;
    end
  end

  assign mem_addr      = r_pc;
  assign mem_req       = (r_state == ST_BUSY);
  assign busy          = (r_state != ST_IDLE);
  assign fetch_done    = (r_state == ST_DONE);
  assign pc            = r_pc;
  assign ir            = r_ir;
  assign opcode        = r_ir[OPCODE_HI:OPCODE_LO];
  assign err_overflow  = r_err_ovf;
  assign err_underflow = r_err_unf;

  a_sp_sane: assert property (@(posedge clk) disable iff (rst)
    (w_sp <= SP_W'(STACK_DEPTH)) && !(w_full && w_empty));
endmodule
